axi_cmd_master: RTL
===================

AXI_CMD_MASTER -- requirements
Module: axi_cmd_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h6400_0000: region base; ARADDR/AWADDR = BASE_ADDR | {20'h0, cmd_offset}.
REQ-002 SHALL have parameter ID_INIT, default 16'h0001: transaction ID issued after reset.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port ARESET, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have command ports: cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write), cmd_offset in 12, cmd_wdata in 32, cmd_wstrb in 4.
REQ-006 SHALL have response ports: rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_resp out 2, rsp_id out 16, rsp_err out 1 (ID/RLAST protocol error).
REQ-007 SHALL have AXI AR/R ports: ARID out 16, ARADDR out 32, ARLEN out 4, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1, RID in 16, RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.
REQ-008 SHALL have AXI AW/W/B ports: AWID out 16, AWADDR out 32, AWLEN out 4, AWSIZE out 3, AWBURST out 2, AWVALID out 1, AWREADY in 1, WDATA out 32, WSTRB out 8, WVALID out 1, WREADY in 1, BID in 16, BRESP in 2, BVALID in 1, BREADY out 1.

Function
REQ-009 SHALL issue single-beat transfers only: AxLEN=4'h0, AxSIZE=3'b010, AxBURST=2'b01, constant.
REQ-010 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP; one command outstanding at a time.
REQ-011 SHALL assert cmd_ready only in IDLE; a cmd_valid&cmd_ready handshake registers the command and moves to RD_ADDR (cmd_write=0) or WR_REQ (cmd_write=1).
REQ-012 SHALL assert ARVALID (or AWVALID and WVALID) in the first cycle after command acceptance, with all address/ID/data fields registered and stable until the corresponding handshake.
REQ-013 RD_ADDR: SHALL hold ARVALID until ARVALID&ARREADY, then deassert ARVALID and enter RD_DATA.
REQ-014 RD_DATA: SHALL hold RREADY=1; on RVALID, capture RDATA, RRESP, RID, RLAST and enter RSP.
REQ-015 WR_REQ: SHALL assert AWVALID and WVALID together; each SHALL drop the cycle after its own handshake, independently; enter WR_RESP once both have completed (same-cycle or either order).
REQ-016 SHALL drive WSTRB = {4'h0, cmd_wstrb}.
REQ-017 WR_RESP: SHALL hold BREADY=1; on BVALID, capture BRESP and BID, set rsp_rdata=0, enter RSP.
REQ-018 RSP: SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready, then return to IDLE; rsp_id SHALL be the issued ID.
REQ-019 SHALL pass RRESP/BRESP unmodified to rsp_resp (SLVERR 2'b10 reported, not retried).
REQ-020 SHALL increment the 16-bit ID counter on each accepted command, wrapping 16'hFFFF -> 16'h0000.
REQ-021 Minimum latency with zero-wait slave: cmd handshake cycle N -> AxVALID N+1 -> R/B handshake N+2 at the earliest -> rsp_valid N+3.

Reset
REQ-022 While ARESET=1 at a clock edge: FSM=IDLE, ID counter=ID_INIT, all VALID/READY outputs=0, rsp_rdata=0, rsp_resp=0, rsp_id=0, rsp_err=0, ARADDR/AWADDR/WDATA/WSTRB/ARID/AWID=0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction without emitting a response; the first command after reset uses ID_INIT.

Configuration
REQ-024 With AXI_CMD_MASTER_IDCHK_EN defined: rsp_err=1 when the captured RID/BID differs from the issued ID, or when RLAST=0 on a read; response still delivered.
REQ-025 Without AXI_CMD_MASTER_IDCHK_EN: rsp_err SHALL be constant 0 and no ID/RLAST comparison logic SHALL exist.

Verification
REQ-026 Read, offset 12'h000, zero-wait slave returns RDATA=32'hA5A5_0001, RRESP=00 -> ARADDR=32'h6400_0000, ARID=16'h0001; rsp_valid 3 cycles after cmd handshake; rsp_rdata=32'hA5A5_0001, rsp_id=1.
REQ-027 Write offset 12'h004, wdata 32'hDEAD_BEEF, wstrb 4'h3; AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops first, AWVALID held; WSTRB=8'h03; one B handshake; rsp_resp=00.
REQ-028 Read offset 12'h100, slave RRESP=2'b10 -> rsp_resp=2'b10, rsp_err=0.
REQ-029 IDCHK_EN build: slave returns RID=16'hABCD for issued ID 16'h0005 -> rsp_err=1; default build -> rsp_err=0.
REQ-030 Hold rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0 throughout; ID after 16'hFFFF commands wraps to 16'h0000; ARESET during RD_DATA -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/axi_cmd_master.sv
// axi_cmd_master: turns one command at a time into a single-beat AXI4 read or
// write, then presents the slave response on the rsp_* channel.
// Optional build macro AXI_CMD_MASTER_IDCHK_EN: rsp_err flags a RID/BID that
// differs from the issued ID, or a read returned without RLAST.
module axi_cmd_master #(
   parameter logic [31:0] BASE_ADDR = 32'h6400_0000,
   parameter logic [15:0] ID_INIT   = 16'h0001
) (
   input  logic        ACLK,
   input  logic        ARESET,
   // command channel
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [11:0] cmd_offset,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   // response channel
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic [15:0] rsp_id,
   output logic        rsp_err,
   // AXI read address / read data
   output logic [15:0] ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [15:0] RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   // AXI write address / write data / write response
   output logic [15:0] AWID,
   output logic [31:0] AWADDR,
   output logic [3:0]  AWLEN,
   output logic [2:0]  AWSIZE,
   output logic [1:0]  AWBURST,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [31:0] WDATA,
   output logic [7:0]  WSTRB,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic [15:0] BID,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t      state_r;
   logic [15:0] next_id_r;
   logic [15:0] txid_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;
   logic        cmd_ready_r;
   logic        arvalid_r;
   logic        rready_r;
   logic        awvalid_r;
   logic        wvalid_r;
   logic        bready_r;
   logic        rsp_valid_r;
   logic [31:0] rsp_rdata_r;
   logic [1:0]  rsp_resp_r;
   logic [15:0] rsp_id_r;
   logic        aw_done_s;
   logic        w_done_s;

   // A write channel is done once its VALID has dropped or it handshakes now
   assign aw_done_s = ~awvalid_r | AWREADY;
   assign w_done_s  = ~wvalid_r | WREADY;

   // Command sequencer: accept, issue one AXI transfer, capture and return response
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_r     <= IDLE;
         next_id_r   <= ID_INIT;
         txid_r      <= 16'h0000;
         addr_r      <= 32'h0000_0000;
         wdata_r     <= 32'h0000_0000;
         wstrb_r     <= 4'h0;
         cmd_ready_r <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_resp_r  <= 2'b00;
         rsp_id_r    <= 16'h0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_ready_r && cmd_valid) begin
                  cmd_ready_r <= 1'b0;
                  addr_r      <= BASE_ADDR | {20'h0_0000, cmd_offset};
                  txid_r      <= next_id_r;
                  next_id_r   <= next_id_r + 16'h0001;
                  if (cmd_write) begin
                     wdata_r   <= cmd_wdata;
                     wstrb_r   <= cmd_wstrb;
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     state_r   <= WR_REQ;
                  end else begin
                     arvalid_r <= 1'b1;
                     state_r   <= RD_ADDR;
                  end
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            RD_ADDR: begin
               if (ARREADY) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state_r   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (RVALID) begin
                  rready_r    <= 1'b0;
                  rsp_rdata_r <= RDATA;
                  rsp_resp_r  <= RRESP;
                  rsp_id_r    <= txid_r;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RSP;
               end
            end
            WR_REQ: begin
               if (AWREADY) begin
                  awvalid_r <= 1'b0;
               end
               if (WREADY) begin
                  wvalid_r <= 1'b0;
               end
               if (aw_done_s && w_done_s) begin
                  awvalid_r <= 1'b0;
                  wvalid_r  <= 1'b0;
                  bready_r  <= 1'b1;
                  state_r   <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (BVALID) begin
                  bready_r    <= 1'b0;
                  rsp_rdata_r <= 32'h0000_0000;
                  rsp_resp_r  <= BRESP;
                  rsp_id_r    <= txid_r;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef AXI_CMD_MASTER_IDCHK_EN
   logic rsp_err_r;

   // Flag an ID mismatch (or a read without RLAST) when the response is captured
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rsp_err_r <= 1'b0;
      end else if ((state_r == RD_DATA) && RVALID) begin
         rsp_err_r <= (RID != txid_r) || !RLAST;
      end else if ((state_r == WR_RESP) && BVALID) begin
         rsp_err_r <= (BID != txid_r);
      end else begin
         rsp_err_r <= rsp_err_r;
      end
   end

   assign rsp_err = rsp_err_r;
`else
   logic unused_s;
   assign unused_s = ^{1'b0, RID, RLAST, BID};
   assign rsp_err  = 1'b0;
`endif

   assign cmd_ready = cmd_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_resp  = rsp_resp_r;
   assign rsp_id    = rsp_id_r;

   assign ARID    = txid_r;
   assign ARADDR  = addr_r;
   assign ARLEN   = 4'h0;
   assign ARSIZE  = 3'b010;
   assign ARBURST = 2'b01;
   assign ARVALID = arvalid_r;
   assign RREADY  = rready_r;

   assign AWID    = txid_r;
   assign AWADDR  = addr_r;
   assign AWLEN   = 4'h0;
   assign AWSIZE  = 3'b010;
   assign AWBURST = 2'b01;
   assign AWVALID = awvalid_r;
   assign WDATA   = wdata_r;
   assign WSTRB   = {4'h0, wstrb_r};
   assign WVALID  = wvalid_r;
   assign BREADY  = bready_r;

endmodule
